// File: rtl/priority_codec_pkg.sv
// Shared definitions for the priority encoder/decoder pair: default widths,
// FSM state encoding and the hold-length helper.
package priority_codec_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int OUT_W_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DRIVE = ST_DRIVE,
        S_GAP   = ST_GAP
    } state_t;

    // A zero hold setting still produces a one-cycle strobe.
    function automatic int unsigned hold_len(input int unsigned cfg);
        return (cfg == 0) ? 1 : cfg;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pop data is the head entry, valid whenever not empty.
// Push ignored while full and pop ignored while empty; full/empty derive from a registered count.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/priority_decoder_seq.sv
// Replays queued channel indices as one-hot strobes held H cycles plus one idle gap (period H+1).
// First strobe appears the cycle after the pop edge; in_ready drops while the FIFO is full.
module priority_decoder_seq
    import priority_codec_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [HOLD_W-1:0] hold_cfg,
    output logic [OUT_W-1:0]  onehot_out,
    output logic [IDX_W-1:0]  idx_out,
    output logic              busy,
    output logic              err
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [OUT_W-1:0]  r_onehot;
    logic [IDX_W-1:0]  r_idx;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_bad_idx;
    logic [IDX_W-1:0]  w_pop_dat;
    logic [CNT_W-1:0]  w_count;

    assign w_push    = in_valid && !w_full;
    assign w_pop     = !w_empty && (r_state != S_DRIVE);
    assign w_bad_idx = (32'(w_pop_dat) >= OUT_W);

    sync_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (in_idx),
        .i_pop      (w_pop),
        .o_pop_dat  (w_pop_dat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_onehot <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_DRIVE: begin
                    if (r_hold == '0) begin
                        r_state  <= S_GAP;
                        r_onehot <= '0;
                        r_idx    <= '0;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: begin
                    r_onehot <= '0;
                    r_idx    <= '0;
                    if (!w_pop) begin
                        r_state <= S_IDLE;
                    end else if (w_bad_idx) begin
                        // Unmappable index is consumed silently apart from the sticky flag.
                        r_err   <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_state  <= S_DRIVE;
                        r_onehot <= OUT_W'(1) << w_pop_dat;
                        r_idx    <= w_pop_dat;
                        r_hold   <= HOLD_W'(hold_len(32'(hold_cfg)) - 32'd1);
                    end
                end
            endcase
        end
    end

    assign in_ready   = !w_full;
    assign onehot_out = r_onehot;
    assign idx_out    = r_idx;
    assign busy       = (r_state != S_IDLE) || (w_count != '0);
    assign err        = r_err;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Directed bench for priority_decoder_seq: default 16-output instance plus a 12-output
// instance for the out-of-range index path.
module tb_priority_decoder_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [3:0]  hold_cfg = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_idx = '0;
    logic        in_ready;
    logic [15:0] onehot_out;
    logic [3:0]  idx_out;
    logic        busy;
    logic        err;

    logic        in_valid12 = 1'b0;
    logic [3:0]  in_idx12 = '0;
    logic        in_ready12;
    logic [11:0] onehot12;
    logic [3:0]  idx_out12;
    logic        busy12;
    logic        err12;

    int n_checks = 0;
    int n_errors = 0;

    priority_decoder_seq u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .hold_cfg   (hold_cfg),
        .onehot_out (onehot_out),
        .idx_out    (idx_out),
        .busy       (busy),
        .err        (err)
    );

    priority_decoder_seq #(.OUT_W(12)) u_dut12 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid12),
        .in_ready   (in_ready12),
        .in_idx     (in_idx12),
        .hold_cfg   (hold_cfg),
        .onehot_out (onehot12),
        .idx_out    (idx_out12),
        .busy       (busy12),
        .err        (err12)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_checks++;
        if (onehot_out !== 16'h0000) begin n_errors++; $display("FAIL reset_onehot got %h exp 0000", onehot_out); end
        n_checks++;
        if (idx_out !== 4'd0) begin n_errors++; $display("FAIL reset_idx got %0d exp 0", idx_out); end
        n_checks++;
        if ({busy, err, in_ready} !== 3'b001) begin n_errors++; $display("FAIL reset_flags busy/err/rdy got %b exp 001", {busy, err, in_ready}); end
        n_checks++;
        if ({onehot12, busy12, err12, in_ready12} !== {12'h000, 3'b001}) begin
            n_errors++; $display("FAIL reset_dut12 got %h/%b exp 000/001", onehot12, {busy12, err12, in_ready12});
        end
    endtask

    task automatic test_single();
        logic [15:0] exp_oh [6];
        logic        exp_busy [6];
        exp_oh   = '{16'h0000, 16'h0080, 16'h0080, 16'h0080, 16'h0000, 16'h0000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        hold_cfg = 4'd3;
        in_idx   = 4'd7;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            in_valid = 1'b0;
            n_checks++;
            if (onehot_out !== exp_oh[c]) begin n_errors++; $display("FAIL single_onehot cyc %0d got %h exp %h", c, onehot_out, exp_oh[c]); end
            n_checks++;
            if (busy !== exp_busy[c]) begin n_errors++; $display("FAIL single_busy cyc %0d got %b exp %b", c, busy, exp_busy[c]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  push_tbl [3];
        logic [15:0] exp_oh [8];
        logic [3:0]  exp_idx [8];
        push_tbl = '{4'd0, 4'd15, 4'd5};
        exp_oh   = '{16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h0000, 16'h0020, 16'h0000, 16'h0000};
        exp_idx  = '{4'd0, 4'd0, 4'd0, 4'd15, 4'd0, 4'd5, 4'd0, 4'd0};
        hold_cfg = 4'd1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 3);
            in_idx   = (c < 3) ? push_tbl[c] : 4'd0;
            step();
            n_checks++;
            if (onehot_out !== exp_oh[c] || idx_out !== exp_idx[c]) begin
                n_errors++; $display("FAIL b2b_out cyc %0d got %h/%0d exp %h/%0d", c, onehot_out, idx_out, exp_oh[c], exp_idx[c]);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy got %b exp 0", busy); end
    endtask

    task automatic test_hold_zero();
        logic [15:0] exp_oh [4];
        exp_oh   = '{16'h0000, 16'h0008, 16'h0000, 16'h0000};
        hold_cfg = 4'd0;
        in_idx   = 4'd3;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            in_valid = 1'b0;
            n_checks++;
            if (onehot_out !== exp_oh[c]) begin n_errors++; $display("FAIL hold0_onehot cyc %0d got %h exp %h", c, onehot_out, exp_oh[c]); end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL hold0_busy got %b exp 0", busy); end
    endtask

    task automatic test_fill_stall();
        logic [3:0]  tbl [6];
        logic [15:0] prev;
        logic        rdy_before;
        logic        multi_hot;
        int p, q, stalls, on_cycles;
        tbl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd10};
        prev = '0; multi_hot = 1'b0;
        p = 0; q = 0; stalls = 0; on_cycles = 0;
        hold_cfg = 4'd4;
        for (int c = 0; c < 45; c++) begin
            in_valid = (p < 6);
            in_idx   = (p < 6) ? tbl[p] : 4'd0;
            rdy_before = in_ready;
            if (in_valid && !rdy_before) stalls++;
            step();
            if (in_valid && rdy_before) p++;
            if (!$onehot0(onehot_out)) multi_hot = 1'b1;
            if (onehot_out != 16'h0000) begin
                on_cycles++;
                if (prev == 16'h0000) begin
                    n_checks++;
                    if (q >= 6) begin
                        n_errors++; $display("FAIL fill_extra_strobe got %h exp none", onehot_out);
                    end else if (onehot_out !== (16'h0001 << tbl[q])) begin
                        n_errors++; $display("FAIL fill_order entry %0d got %h exp %h", q, onehot_out, 16'h0001 << tbl[q]);
                    end
                    q++;
                end
            end
            prev = onehot_out;
        end
        in_valid = 1'b0;
        n_checks++;
        if (stalls !== 2) begin n_errors++; $display("FAIL fill_stall_cycles got %0d exp 2", stalls); end
        n_checks++;
        if (p !== 6 || q !== 6) begin n_errors++; $display("FAIL fill_counts pushed %0d strobes %0d exp 6/6", p, q); end
        n_checks++;
        if (on_cycles !== 24) begin n_errors++; $display("FAIL fill_strobe_cycles got %0d exp 24", on_cycles); end
        n_checks++;
        if (multi_hot || busy !== 1'b0) begin n_errors++; $display("FAIL fill_end multihot %b busy %b exp 0/0", multi_hot, busy); end
    endtask

    task automatic test_out_of_range();
        logic [11:0] exp_oh [5];
        logic        exp_err [5];
        exp_oh   = '{12'h000, 12'h000, 12'h004, 12'h000, 12'h000};
        exp_err  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        hold_cfg = 4'd1;
        for (int c = 0; c < 5; c++) begin
            in_valid12 = (c < 2);
            in_idx12   = (c == 0) ? 4'd13 : ((c == 1) ? 4'd2 : 4'd0);
            step();
            n_checks++;
            if (onehot12 !== exp_oh[c] || err12 !== exp_err[c]) begin
                n_errors++; $display("FAIL oor_out cyc %0d got %h/err %b exp %h/err %b", c, onehot12, err12, exp_oh[c], exp_err[c]);
            end
        end
        in_valid12 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (err12 !== 1'b0) begin n_errors++; $display("FAIL oor_err_clear got %b exp 0", err12); end
    endtask

    task automatic test_reset_mid_drive();
        logic leaked;
        leaked   = 1'b0;
        hold_cfg = 4'd8;
        in_valid = 1'b1; in_idx = 4'd9; step();
        in_idx = 4'd1; step();
        in_idx = 4'd2; step();
        in_valid = 1'b0;
        n_checks++;
        if (onehot_out !== 16'h0200) begin n_errors++; $display("FAIL mid_drive_pre got %h exp 0200", onehot_out); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (onehot_out !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL mid_drive_reset got %h busy %b rdy %b exp 0000/0/1", onehot_out, busy, in_ready);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            if (onehot_out != 16'h0000 || busy) leaked = 1'b1;
        end
        n_checks++;
        if (leaked) begin n_errors++; $display("FAIL mid_drive_leak got %b exp 0", leaked); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_zero();
        test_fill_stall();
        test_out_of_range();
        test_reset_mid_drive();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
